r_return_mux: RTL and testbench

R_RETURN_MUX -- requirements
Module: r_return_mux

---
 rtl/r_return_mux.sv | 147 ++++++++++++++
 tb/tb_r_return_mux.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/r_return_mux.sv
// R-channel return mux: arbitrates read bursts from two slaves plus an internal
// DECERR responder for unmapped addresses onto a single master R port.
module r_return_mux #(
  parameter int AXI_ID_BITS   = 4,
  parameter int AXI_IDS_BITS  = 8,
  parameter int AXI_ADDR_BITS = 32,
  parameter int AXI_LEN_BITS  = 4,
  parameter int AXI_DATA_BITS = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [AXI_ID_BITS+3:0]    ARID_M,
  input  logic [AXI_ADDR_BITS-1:0]  ARADDR_M,
  input  logic [AXI_LEN_BITS-1:0]   ARLEN_M,
  input  logic                      ARVALID_M,
  output logic                      ARREADY_DEF,
  input  logic [AXI_IDS_BITS+3:0]   RID_S0,
  input  logic [AXI_DATA_BITS-1:0]  RDATA_S0,
  input  logic [1:0]                RRESP_S0,
  input  logic                      RLAST_S0,
  input  logic                      RVALID_S0,
  output logic                      RREADY_S0,
  input  logic [AXI_IDS_BITS+3:0]   RID_S1,
  input  logic [AXI_DATA_BITS-1:0]  RDATA_S1,
  input  logic [1:0]                RRESP_S1,
  input  logic                      RLAST_S1,
  input  logic                      RVALID_S1,
  output logic                      RREADY_S1,
  output logic [AXI_ID_BITS+3:0]    RID_M,
  output logic [AXI_DATA_BITS-1:0]  RDATA_M,
  output logic [1:0]                RRESP_M,
  output logic                      RLAST_M,
  output logic                      RVALID_M,
  input  logic                      RREADY_M
);
  localparam int IDW  = AXI_ID_BITS + 4;
  localparam int IDSW = AXI_IDS_BITS + 4;
  localparam logic [AXI_ADDR_BITS-1:0] MAP_TOP = AXI_ADDR_BITS'(32'h0001_FFFF);

  typedef struct packed {
    logic [IDW-1:0]           id;
    logic [AXI_DATA_BITS-1:0] data;
    logic [1:0]               resp;
    logic                     last;
    logic                     valid;
  } r_beat_t;

  typedef enum logic [1:0] {IDLE, OWN_S0, OWN_S1, OWN_DEF} own_e;
  typedef enum logic {DEF_IDLE, DEF_BUSY} def_e;

  own_e                    own_q, own_d;
  def_e                    def_q;
  logic                    prio_q, prio_d;   // 0: S0 wins a tie, 1: S1 wins
  logic                    seen_q;           // a beat has moved in this ownership
  logic [AXI_LEN_BITS-1:0] def_cnt;
  logic [IDW-1:0]          def_id;
  r_beat_t [1:0]           s_beat;
  r_beat_t                 def_beat, m_beat;
  logic                    m_hs, ar_hs, def_hs;

  // Master ID carries only the low bits of the slave-side ID.
  assign s_beat[0] = '{id: RID_S0[IDW-1:0], data: RDATA_S0, resp: RRESP_S0,
                       last: RLAST_S0, valid: RVALID_S0};
  assign s_beat[1] = '{id: RID_S1[IDW-1:0], data: RDATA_S1, resp: RRESP_S1,
                       last: RLAST_S1, valid: RVALID_S1};

  generate
    if (IDSW > IDW) begin : g_id_trunc
      logic unused_id_bits;
      assign unused_id_bits = ^{RID_S0[IDSW-1:IDW], RID_S1[IDSW-1:IDW]};
    end
  endgenerate

  assign def_beat = '{id: def_id, data: '0, resp: 2'b11,
                      last: (def_cnt == '0), valid: (def_q == DEF_BUSY)};

  always_comb begin
    own_d  = own_q;
    prio_d = prio_q;
    m_beat = '0;
    unique case (own_q)
      OWN_S0:  m_beat = s_beat[0];
      OWN_S1:  m_beat = s_beat[1];
      OWN_DEF: m_beat = def_beat;
      default: begin
        if (def_beat.valid)
          own_d = OWN_DEF;
        else if (s_beat[0].valid && (!s_beat[1].valid || !prio_q))
          own_d = OWN_S0;
        else if (s_beat[1].valid)
          own_d = OWN_S1;
      end
    endcase
    m_hs = m_beat.valid && RREADY_M;
    if (own_q != IDLE) begin
      if (m_hs && m_beat.last) begin
        own_d = IDLE;
        if (own_q == OWN_S0)      prio_d = 1'b1;
        else if (own_q == OWN_S1) prio_d = 1'b0;
      end else if (!seen_q && !m_beat.valid) begin
        // source withdrew its valid before any beat moved
        own_d = IDLE;
      end
    end
  end

  assign RID_M    = m_beat.id;
  assign RDATA_M  = m_beat.data;
  assign RRESP_M  = m_beat.resp;
  assign RLAST_M  = m_beat.last;
  assign RVALID_M = m_beat.valid;

  assign RREADY_S0 = RREADY_M && (own_q == OWN_S0);
  assign RREADY_S1 = RREADY_M && (own_q == OWN_S1);

  // Gated by reset so the AR accept stays low while ARESETn is held.
  assign ARREADY_DEF = ARESETn && ARVALID_M && (ARADDR_M > MAP_TOP) && (def_q == DEF_IDLE);
  assign ar_hs       = ARREADY_DEF;
  assign def_hs      = (own_q == OWN_DEF) && m_hs;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      own_q  <= IDLE;
      prio_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      own_q  <= own_d;
      prio_q <= prio_d;
      seen_q <= (own_d != IDLE) && (seen_q || m_hs);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      def_q   <= DEF_IDLE;
      def_cnt <= '0;
      def_id  <= '0;
    end else if (ar_hs) begin
      def_q   <= DEF_BUSY;
      def_cnt <= ARLEN_M;
      def_id  <= ARID_M;
    end else if (def_hs) begin
      if (def_cnt == '0) def_q <= DEF_IDLE;
      else               def_cnt <= def_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_r_return_mux.sv
// Directed bench for r_return_mux: behavioral slave sources, master-side beat log.
module tb_r_return_mux;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic        ARVALID_M, ARREADY_DEF;
  logic [11:0] RID_S0, RID_S1;
  logic [31:0] RDATA_S0, RDATA_S1;
  logic [1:0]  RRESP_S0, RRESP_S1;
  logic        RLAST_S0, RLAST_S1, RVALID_S0, RVALID_S1, RREADY_S0, RREADY_S1;
  logic [7:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M, RVALID_M, RREADY_M;

  int n_chk = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  r_return_mux dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARVALID_M(ARVALID_M),
    .ARREADY_DEF(ARREADY_DEF),
    .RID_S0(RID_S0), .RDATA_S0(RDATA_S0), .RRESP_S0(RRESP_S0), .RLAST_S0(RLAST_S0),
    .RVALID_S0(RVALID_S0), .RREADY_S0(RREADY_S0),
    .RID_S1(RID_S1), .RDATA_S1(RDATA_S1), .RRESP_S1(RRESP_S1), .RLAST_S1(RLAST_S1),
    .RVALID_S1(RVALID_S1), .RREADY_S1(RREADY_S1),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
  );

  // Slave sources: s_total beats, data = base + beat index, RESP tags the source.
  logic [11:0] s_id   [2];
  logic [31:0] s_base [2];
  int          s_total[2];
  int          s_done [2];
  logic        s_clr  [2];

  assign RVALID_S0 = !s_clr[0] && (s_done[0] < s_total[0]);
  assign RVALID_S1 = !s_clr[1] && (s_done[1] < s_total[1]);
  assign RDATA_S0  = s_base[0] + 32'(s_done[0]);
  assign RDATA_S1  = s_base[1] + 32'(s_done[1]);
  assign RLAST_S0  = (s_done[0] == s_total[0] - 1);
  assign RLAST_S1  = (s_done[1] == s_total[1] - 1);
  assign RID_S0    = s_id[0];
  assign RID_S1    = s_id[1];
  assign RRESP_S0  = 2'b00;
  assign RRESP_S1  = 2'b01;

  always @(posedge ACLK) begin
    if (s_clr[0])                    s_done[0] <= 0;
    else if (RVALID_S0 && RREADY_S0) s_done[0] <= s_done[0] + 1;
    if (s_clr[1])                    s_done[1] <= 0;
    else if (RVALID_S1 && RREADY_S1) s_done[1] <= s_done[1] + 1;
  end

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;
  beat_t lg[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic record();
    if (RVALID_M && RREADY_M)
      lg.push_back('{id: RID_M, data: RDATA_M, resp: RRESP_M, last: RLAST_M});
  endtask

  task automatic run(input int n, input bit tog = 0, input bit watch_s0 = 0);
    repeat (n) begin
      @(posedge ACLK); #1;
      if (tog) RREADY_M = ~RREADY_M;
      @(negedge ACLK);
      record();
      if (watch_s0) chk("bp_rready_s0", RREADY_S0, 0);
    end
  endtask

  task automatic prep(input int x, input logic [11:0] id, input logic [31:0] base, input int n);
    s_id[x] = id; s_base[x] = base; s_total[x] = n; s_clr[x] = 1'b1;
  endtask

  task automatic go(input logic [1:0] mask);
    @(posedge ACLK); #1;
    if (mask[0]) s_clr[0] = 1'b0;
    if (mask[1]) s_clr[1] = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [7:0] id,
                          input logic [31:0] d, input logic [1:0] r, input logic l);
    if (i < lg.size()) chk(tag, {lg[i].id, lg[i].data, lg[i].resp, lg[i].last}, {id, d, r, l});
    else               chk(tag, 64'(lg.size()), 64'(i + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ARESETn = 1'b0; ARVALID_M = 1'b0; ARID_M = '0; ARADDR_M = '0; ARLEN_M = '0;
    RREADY_M = 1'b1;
    for (int x = 0; x < 2; x++) begin
      s_clr[x] = 1'b1; s_total[x] = 0; s_id[x] = '0; s_base[x] = '0;
    end

    // reset holds every output low even with live inputs
    repeat (2) @(posedge ACLK);
    #1;
    s_clr[0] = 1'b0; s_total[0] = 1; ARVALID_M = 1'b1; ARADDR_M = 32'h0003_0000;
    @(negedge ACLK);
    chk("rst_rvalid", RVALID_M, 0);
    chk("rst_rready_s0", RREADY_S0, 0);
    chk("rst_arready", ARREADY_DEF, 0);
    chk("rst_rdata", RDATA_M, 0);
    @(posedge ACLK); #1;
    ARVALID_M = 1'b0; s_clr[0] = 1'b1;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rst_idle", RVALID_M, 0);

    // contention from reset: S0 first, then S1
    lg.delete();
    prep(0, 12'h301, 32'h2000, 2);
    prep(1, 12'h402, 32'h3000, 2);
    go(2'b11);
    @(negedge ACLK);
    chk("c1_grant_wait", RVALID_M, 0);
    run(6);
    chk("c1_n", lg.size(), 4);
    chk_beat("c1_b0", 0, 8'h01, 32'h2000, 2'b00, 1'b0);
    chk_beat("c1_b1", 1, 8'h01, 32'h2001, 2'b00, 1'b1);
    chk_beat("c1_b2", 2, 8'h02, 32'h3000, 2'b01, 1'b0);
    chk_beat("c1_b3", 3, 8'h02, 32'h3001, 2'b01, 1'b1);

    // S1 burst under toggling backpressure
    lg.delete();
    prep(1, 12'h5A7, 32'h4000, 3);
    RREADY_M = 1'b0;
    go(2'b10);
    @(negedge ACLK);
    chk("bp_wait", RVALID_M, 0);
    run(7, 1, 1);
    RREADY_M = 1'b1;
    chk("bp_n", lg.size(), 3);
    chk_beat("bp_b0", 0, 8'hA7, 32'h4000, 2'b01, 1'b0);
    chk_beat("bp_b1", 1, 8'hA7, 32'h4001, 2'b01, 1'b0);
    chk_beat("bp_b2", 2, 8'hA7, 32'h4002, 2'b01, 1'b1);

    // single S0 burst, 4 beats
    lg.delete();
    prep(0, 12'hA12, 32'h1000, 4);
    go(2'b01);
    @(negedge ACLK);
    chk("s0_wait", RVALID_M, 0);
    run(4);
    chk("s0_n", lg.size(), 4);
    chk_beat("s0_b0", 0, 8'h12, 32'h1000, 2'b00, 1'b0);
    chk_beat("s0_b1", 1, 8'h12, 32'h1001, 2'b00, 1'b0);
    chk_beat("s0_b2", 2, 8'h12, 32'h1002, 2'b00, 1'b0);
    chk_beat("s0_b3", 3, 8'h12, 32'h1003, 2'b00, 1'b1);
    run(1);
    chk("s0_idle", RVALID_M, 0);

    // repeat contention: priority now with S1
    lg.delete();
    prep(0, 12'h303, 32'h2100, 1);
    prep(1, 12'h404, 32'h3100, 1);
    go(2'b11);
    @(negedge ACLK);
    run(4);
    chk("c2_n", lg.size(), 2);
    chk_beat("c2_b0", 0, 8'h04, 32'h3100, 2'b01, 1'b1);
    chk_beat("c2_b1", 1, 8'h03, 32'h2100, 2'b00, 1'b1);

    // mapped boundary address is not taken by the default responder
    @(posedge ACLK); #1;
    ARVALID_M = 1'b1; ARADDR_M = 32'h0001_FFFF; ARID_M = 8'h35; ARLEN_M = 4'd2;
    @(negedge ACLK);
    chk("ar_mapped_top", ARREADY_DEF, 0);

    // DECERR burst of 3
    lg.delete();
    @(posedge ACLK); #1;
    ARADDR_M = 32'h0002_0000;
    @(negedge ACLK);
    chk("dec_ardy", ARREADY_DEF, 1);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("dec_ardy_1cyc", ARREADY_DEF, 0);
    chk("dec_wait", RVALID_M, 0);
    ARVALID_M = 1'b0;
    run(4);
    chk("dec_n", lg.size(), 3);
    chk_beat("dec_b0", 0, 8'h35, 32'h0, 2'b11, 1'b0);
    chk_beat("dec_b1", 1, 8'h35, 32'h0, 2'b11, 1'b0);
    chk_beat("dec_b2", 2, 8'h35, 32'h0, 2'b11, 1'b1);

    // second unmapped AR held during a DEF burst
    lg.delete();
    @(posedge ACLK); #1;
    ARVALID_M = 1'b1; ARADDR_M = 32'h0003_0000; ARID_M = 8'h11; ARLEN_M = 4'd1;
    @(negedge ACLK);
    chk("busy_ardy_first", ARREADY_DEF, 1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge ACLK); #1;
      if (i == 1) begin
        ARADDR_M = 32'h0004_0000; ARID_M = 8'h22; ARLEN_M = 4'd0;
      end
      @(negedge ACLK);
      record();
      chk($sformatf("busy_ardy_c%0d", i), ARREADY_DEF, (i == 4));
    end
    @(posedge ACLK); #1;
    ARVALID_M = 1'b0;
    @(negedge ACLK);
    record();
    run(3);
    chk("busy_n", lg.size(), 3);
    chk_beat("busy_b0", 0, 8'h11, 32'h0, 2'b11, 1'b0);
    chk_beat("busy_b1", 1, 8'h11, 32'h0, 2'b11, 1'b1);
    chk_beat("busy_b2", 2, 8'h22, 32'h0, 2'b11, 1'b1);

    // reset on beat 2 of a 4-beat S0 burst (priority currently with S1)
    lg.delete();
    prep(0, 12'h6B8, 32'h5000, 4);
    go(2'b01);
    @(negedge ACLK);
    run(2);
    chk("mid_pre_vld", RVALID_M, 1);
    ARESETn = 1'b0; ARVALID_M = 1'b1; ARADDR_M = 32'h0005_0000;
    #1;
    chk("mid_rvalid", RVALID_M, 0);
    chk("mid_rlast", RLAST_M, 0);
    chk("mid_rdata", RDATA_M, 0);
    chk("mid_rresp", RRESP_M, 0);
    chk("mid_rid", RID_M, 0);
    chk("mid_rready_s0", RREADY_S0, 0);
    chk("mid_rready_s1", RREADY_S1, 0);
    chk("mid_arready", ARREADY_DEF, 0);
    ARVALID_M = 1'b0; s_clr[0] = 1'b1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    lg.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      record();
      chk("post_rst_idle", RVALID_M, 0);
    end
    chk("post_rst_stale", lg.size(), 0);
    prep(0, 12'h7C1, 32'h6000, 1);
    prep(1, 12'h7D2, 32'h7000, 1);
    go(2'b11);
    @(negedge ACLK);
    run(4);
    chk("post_rst_n", lg.size(), 2);
    chk_beat("post_rst_b0", 0, 8'hC1, 32'h6000, 2'b00, 1'b1);
    chk_beat("post_rst_b1", 1, 8'hD2, 32'h7000, 2'b01, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
